// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Data-memory bus with a req/ack handshake (one access in flight).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM stage: runs loads/stores on the data bus, stalls the pipeline
//            while an access is outstanding and drives the MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire                clk,
    input  wire                reset,
    input  wire                i_reg_write,
    input  wire  [1:0]         i_mem_to_reg,
    input  wire                i_mem_read,
    input  wire                i_mem_write,
    input  wire  [5:0]         i_write_register,
    input  wire  [31:0]        i_pc_4,
    input  wire  [31:0]        i_data_2,
    input  wire  [31:0]        i_alu_result,
    mem_access_unit_if.master  bus,
    output logic               o_stall,
    output logic               o_reg_write,
    output logic [1:0]         o_mem_to_reg,
    output logic [5:0]         o_write_register,
    output logic [31:0]        o_pc_4,
    output logic [31:0]        o_alu_result,
    output logic [31:0]        o_read_data,
    output logic               o_align_fault,
    output logic               o_bus_error
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_count;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        r_reg_write;
    logic [1:0]  r_mem_to_reg;
    logic [5:0]  r_write_register;
    logic [31:0] r_pc_4;
    logic [31:0] r_alu_result;
    logic [31:0] r_read_data;
    logic        r_align_fault;
    logic        r_bus_error;

    logic w_mem_op;
    logic w_misaligned;
    logic w_start;
    logic w_ack_done;
    logic w_timeout;
    logic w_stall;

    assign w_mem_op     = i_mem_read | i_mem_write;
    assign w_misaligned = w_mem_op & (i_alu_result[1:0] != 2'b00);

    // The abort cycle is ACCESS cycle TIMEOUT+1, so the pipeline sees
    // TIMEOUT+1 stalled cycles (detect cycle plus TIMEOUT ACCESS cycles).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_misaligned) begin
                    w_start     = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_count == c_timeout) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_stall = w_stall & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= 8'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_count     <= 8'd0;
                r_bus_req   <= 1'b1;
                r_bus_we    <= i_mem_write;
                r_bus_addr  <= i_alu_result;
                r_bus_wdata <= i_data_2;
            end else if (w_ack_done || w_timeout) begin
                r_bus_req <= 1'b0;
            end else if (r_state == S_ACCESS) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // MEM/WB: a stall inserts a bubble by clearing only the side-effect flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write      <= 1'b0;
            r_mem_to_reg     <= 2'd0;
            r_write_register <= 6'd0;
            r_pc_4           <= 32'd0;
            r_alu_result     <= 32'd0;
            r_read_data      <= 32'd0;
            r_align_fault    <= 1'b0;
            r_bus_error      <= 1'b0;
        end else if (w_stall) begin
            r_reg_write   <= 1'b0;
            r_align_fault <= 1'b0;
            r_bus_error   <= 1'b0;
        end else begin
            r_reg_write      <= i_reg_write & ~w_misaligned & ~w_timeout;
            r_mem_to_reg     <= i_mem_to_reg;
            r_write_register <= i_write_register;
            r_pc_4           <= i_pc_4;
            r_alu_result     <= i_alu_result;
            r_read_data      <= (w_ack_done && !r_bus_we) ? bus.rdata : 32'd0;
            r_align_fault    <= w_misaligned;
            r_bus_error      <= w_timeout;
        end
    end

    assign bus.req          = r_bus_req;
    assign bus.we           = r_bus_we;
    assign bus.addr         = r_bus_addr;
    assign bus.wdata        = r_bus_wdata;
    assign o_reg_write      = r_reg_write;
    assign o_mem_to_reg     = r_mem_to_reg;
    assign o_write_register = r_write_register;
    assign o_pc_4           = r_pc_4;
    assign o_alu_result     = r_alu_result;
    assign o_read_data      = r_read_data;
    assign o_align_fault    = r_align_fault;
    assign o_bus_error      = r_bus_error;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench: directed vector table, hand sequences for
//            reset/back-to-back, and random ops against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    localparam int TO = 4;

    typedef struct {
        logic        rw;
        logic [1:0]  mtr;
        logic        mr;
        logic        mw;
        logic [5:0]  wreg;
        logic [31:0] pc4;
        logic [31:0] d2;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          ack_k;     // ACCESS cycle carrying ack; 0 = never
        int          exp_stall;
        logic        exp_regw;
        logic [31:0] exp_rdata;
        logic        exp_af;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_reg_write = 1'b0;
    logic [1:0]  i_mem_to_reg = 2'd0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [5:0]  i_write_register = 6'd0;
    logic [31:0] i_pc_4 = 32'd0;
    logic [31:0] i_data_2 = 32'd0;
    logic [31:0] i_alu_result = 32'd0;
    logic        o_stall;
    logic        o_reg_write;
    logic [1:0]  o_mem_to_reg;
    logic [5:0]  o_write_register;
    logic [31:0] o_pc_4;
    logic [31:0] o_alu_result;
    logic [31:0] o_read_data;
    logic        o_align_fault;
    logic        o_bus_error;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bus_if();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_reg_write      (i_reg_write),
        .i_mem_to_reg     (i_mem_to_reg),
        .i_mem_read       (i_mem_read),
        .i_mem_write      (i_mem_write),
        .i_write_register (i_write_register),
        .i_pc_4           (i_pc_4),
        .i_data_2         (i_data_2),
        .i_alu_result     (i_alu_result),
        .bus              (bus_if.master),
        .o_stall          (o_stall),
        .o_reg_write      (o_reg_write),
        .o_mem_to_reg     (o_mem_to_reg),
        .o_write_register (o_write_register),
        .o_pc_4           (o_pc_4),
        .o_alu_result     (o_alu_result),
        .o_read_data      (o_read_data),
        .o_align_fault    (o_align_fault),
        .o_bus_error      (o_bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: outcome of one instruction derived directly from the stage rules.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        r = v;
        r.exp_rdata = 32'd0;
        r.exp_af    = 1'b0;
        r.exp_err   = 1'b0;
        if (!(v.mr || v.mw)) begin
            r.exp_stall = 0;
            r.exp_regw  = v.rw;
        end else if (v.alu[1:0] != 2'b00) begin
            r.exp_stall = 0;
            r.exp_regw  = 1'b0;
            r.exp_af    = 1'b1;
        end else if (v.ack_k >= 1 && v.ack_k <= TO + 1) begin
            r.exp_stall = v.ack_k;
            r.exp_regw  = v.rw;
            r.exp_rdata = v.mw ? 32'd0 : v.rdata;
        end else begin
            r.exp_stall = TO + 1;
            r.exp_regw  = 1'b0;
            r.exp_err   = 1'b1;
        end
        return r;
    endfunction

    // Entered and left at negedge+1; inputs stay frozen while stalled.
    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        int stalls;
        cyc    = 0;
        stalls = 0;
        i_reg_write      = v.rw;
        i_mem_to_reg     = v.mtr;
        i_mem_read       = v.mr;
        i_mem_write      = v.mw;
        i_write_register = v.wreg;
        i_pc_4           = v.pc4;
        i_data_2         = v.d2;
        i_alu_result     = v.alu;
        bus_if.ack       = 1'b0;
        bus_if.rdata     = $urandom;
        #1;
        while (o_stall === 1'b1 && cyc <= TO + 8) begin
            stalls++;
            if (cyc >= 1) begin
                chk({tag, " req held"}, 32'(bus_if.req), 32'd1);
                chk({tag, " addr held"}, bus_if.addr, v.alu);
                chk({tag, " we held"}, 32'(bus_if.we), 32'(v.mw));
                chk({tag, " wdata held"}, bus_if.wdata, v.d2);
                chk({tag, " bubble regw"}, 32'(o_reg_write), 32'd0);
            end
            @(negedge clk);
            cyc++;
            bus_if.ack   = (cyc == v.ack_k);
            bus_if.rdata = bus_if.ack ? v.rdata : $urandom;
            #1;
        end
        chk({tag, " stall ends"}, 32'(o_stall), 32'd0);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
        @(negedge clk);
        bus_if.ack   = 1'b0;
        bus_if.rdata = $urandom;
        #1;
        chk({tag, " req low"}, 32'(bus_if.req), 32'd0);
        chk({tag, " reg_write"}, 32'(o_reg_write), 32'(v.exp_regw));
        chk({tag, " read_data"}, o_read_data, v.exp_rdata);
        chk({tag, " align_fault"}, 32'(o_align_fault), 32'(v.exp_af));
        chk({tag, " bus_error"}, 32'(o_bus_error), 32'(v.exp_err));
        chk({tag, " alu_result"}, o_alu_result, v.alu);
        chk({tag, " pc_4"}, o_pc_4, v.pc4);
        chk({tag, " wreg"}, 32'(o_write_register), 32'(v.wreg));
        chk({tag, " mem_to_reg"}, 32'(o_mem_to_reg), 32'(v.mtr));
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        // rw mtr mr mw wreg pc4 d2 alu rdata ack_k | stall regw rdata af err
        tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b0, 6'd5,  32'h0000_1004, 32'h0,         32'h0000_1234, 32'h0,         0, 0, 1'b1, 32'h0,         1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b0, 6'd7,  32'h0000_1008, 32'h0,         32'h0000_0100, 32'hCAFE_F00D, 3, 3, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 1'b1, 6'd0,  32'h0000_100C, 32'hA5A5_A5A5, 32'h0000_0200, 32'h1234_5678, 1, 1, 1'b0, 32'h0,         1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 1'b0, 1'b1, 6'd0,  32'h0000_1010, 32'h5A5A_5A5A, 32'h0000_0204, 32'h8765_4321, 1, 1, 1'b0, 32'h0,         1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 1'b1, 1'b0, 6'd9,  32'h0000_1014, 32'h0,         32'h0000_0102, 32'hFFFF_FFFF, 1, 0, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[5] = '{1'b1, 2'd1, 1'b1, 1'b0, 6'd10, 32'h0000_1018, 32'h0,         32'h0000_0180, 32'h1111_2222, 0, 5, 1'b0, 32'h0,         1'b0, 1'b1};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 1'b0, 6'd11, 32'h0000_101C, 32'h0,         32'h0000_0184, 32'hDEAD_BEEF, 5, 5, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 2'd2, 1'b1, 1'b1, 6'd12, 32'h0000_1020, 32'h0BAD_CAFE, 32'h0000_0208, 32'h3333_4444, 2, 2, 1'b1, 32'h0,         1'b0, 1'b0};
        tbl[8] = '{1'b1, 2'd0, 1'b0, 1'b1, 6'd13, 32'h0000_1024, 32'h7777_7777, 32'h0000_020B, 32'h0,         1, 0, 1'b0, 32'h0,         1'b1, 1'b0};

        // Reset with an aligned load presented: no stall, all outputs zero.
        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'd0;
        i_mem_read   = 1'b1;
        i_alu_result = 32'h40;
        #12;
        chk("rst stall", 32'(o_stall), 32'd0);
        chk("rst req", 32'(bus_if.req), 32'd0);
        chk("rst regw", 32'(o_reg_write), 32'd0);
        chk("rst alu", o_alu_result, 32'd0);
        @(negedge clk);
        i_mem_read   = 1'b0;
        i_alu_result = 32'd0;
        reset        = 1'b0;
        #1;

        for (int i = 0; i < 9; i++)
            run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset in the second ACCESS cycle, late ack ignored, then a fresh load.
        v = predict('{1'b1, 2'd1, 1'b1, 1'b0, 6'd20, 32'h2004, 32'h0, 32'h300, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0});
        i_reg_write  = 1'b1;
        i_mem_read   = 1'b1;
        i_mem_write  = 1'b0;
        i_alu_result = v.alu;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre-rst req", 32'(bus_if.req), 32'd1);
        reset = 1'b1;
        #1;
        chk("async rst req", 32'(bus_if.req), 32'd0);
        chk("async rst stall", 32'(o_stall), 32'd0);
        chk("async rst addr", bus_if.addr, 32'd0);
        chk("async rst alu", o_alu_result, 32'd0);
        chk("async rst pc4", o_pc_4, 32'd0);
        i_reg_write  = 1'b0;
        i_mem_read   = 1'b0;
        i_alu_result = 32'h0;
        bus_if.ack   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("late ack req", 32'(bus_if.req), 32'd0);
        chk("late ack stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        bus_if.ack = 1'b0;
        #1;
        chk("late ack rd", o_read_data, 32'd0);
        v.rdata = 32'h600D_D00D;
        v.ack_k = 2;
        run_op(predict(v), "post-rst load");

        for (int i = 0; i < 40; i++) begin
            v.rw    = 1'($urandom);
            v.mtr   = 2'($urandom);
            v.mr    = ($urandom_range(0, 3) != 0);
            v.mw    = ($urandom_range(0, 2) == 0);
            v.wreg  = 6'($urandom);
            v.pc4   = $urandom;
            v.d2    = $urandom;
            v.alu   = $urandom;
            if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
            v.rdata = $urandom;
            v.ack_k = $urandom_range(0, 7);
            run_op(predict(v), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
